// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch
// (IF) and data memory (DM). Only one transaction is in flight at a time:
// grant in IDLE, hold the request to memory in ISSUE until it acks, then
// pulse the owner's rvalid in RESP.
//
// Optional feature, enabled by defining ARB_STARVE_GUARD_EN: an anti-starvation
// counter. It lets IF win one arbitration after STARVE_LIMIT DM grants have
// been made while IF was waiting. Without the macro, DM has strict priority.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; arbitrate and grant combinationally
// ISSUE | mem_req held with the latched command, waiting for mem_ack
// RESP  | owner's rvalid pulses for one cycle; no grant this cycle

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [1:0]        dm_size,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  state_t state_q, state_d;
  owner_t owner_q;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic if_priority;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;

  // IF overrides DM only once the counter has saturated and IF still waits
  assign if_priority = if_req && (starve_cnt_q == CNT_MAX);

  // Count DM grants that left IF waiting; any IF grant clears the count
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else if (if_gnt) begin
      starve_cnt_q <= '0;
    end else if (dm_gnt && if_req && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`else
  assign if_priority = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration and next-state logic; grants exist only in IDLE
  always_comb begin
    state_d = state_q;
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req && !if_priority) begin
          dm_gnt = 1'b1;
        end else if (if_req) begin
          if_gnt = 1'b1;
        end
        if (dm_gnt || if_gnt) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the granted command and capture read data into the owner's register
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 2'd0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (dm_gnt) begin
        owner_q <= OWN_DM;
        we_q    <= dm_we;
        addr_q  <= dm_addr;
        wdata_q <= dm_wdata;
        size_q  <= dm_size;
      end else if (if_gnt) begin
        // fetches are always word reads; wdata is left as is
        owner_q <= OWN_IF;
        we_q    <= 1'b0;
        addr_q  <= if_addr;
        size_q  <= 2'd2;
      end
      // store acks also land here only for DM loads; stores keep old dm_rdata
      if ((state_q == ISSUE) && mem_ack) begin
        if (owner_q == OWN_IF) begin
          if_rdata_q <= mem_rdata;
        end else if (!we_q) begin
          dm_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_size  = size_q;

  assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
  assign dm_rvalid = (state_q == RESP) && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change and outputs are checked
// around the falling edge; the memory side is driven by hand, step by step.
// When compiled with ARB_STARVE_GUARD_EN the starvation section expects IF
// to win every fifth arbitration.

module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [1:0]        dm_size;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_size(dm_size),
    .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_size(mem_size),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one full cycle, landing 1ns after the falling edge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  // one arbitration with both requesters held; memory acks on the first ISSUE cycle
  task automatic serve_one(input string tag, input logic exp_dm);
    chk({tag, " dm_gnt"}, {31'd0, dm_gnt}, {31'd0, exp_dm});
    chk({tag, " if_gnt"}, {31'd0, if_gnt}, {31'd0, !exp_dm});
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_0A0A;
    tick();
    mem_ack = 1'b0;
    chk({tag, " rvalid"}, {30'd0, if_rvalid, dm_rvalid}, exp_dm ? 32'd1 : 32'd2);
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    dm_size   = 2'd0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // reset state
    chk("rst busy",      {31'd0, busy},      32'd0);
    chk("rst mem_req",   {31'd0, mem_req},   32'd0);
    chk("rst gnts",      {30'd0, if_gnt, dm_gnt}, 32'd0);
    chk("rst rvalids",   {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    chk("rst mem_addr",  mem_addr,  32'd0);
    chk("rst if_rdata",  if_rdata,  32'd0);

    // single fetch, ack one cycle after mem_req rises
    if_req  = 1'b1;
    if_addr = 32'h0100_0000;
    #1;
    chk("fetch if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("fetch dm_gnt", {31'd0, dm_gnt}, 32'd0);
    tick();
    if_req = 1'b0;
    #1;
    chk("fetch mem_req",  {31'd0, mem_req}, 32'd1);
    chk("fetch mem_addr", mem_addr, 32'h0100_0000);
    chk("fetch mem_we",   {31'd0, mem_we},  32'd0);
    chk("fetch mem_size", {30'd0, mem_size}, 32'd2);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0013;
    tick();
    mem_ack = 1'b0;
    chk("fetch if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("fetch if_rdata",  if_rdata, 32'h0000_0013);
    chk("fetch dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
    chk("fetch resp gnt",  {30'd0, if_gnt, dm_gnt}, 32'd0);
    tick();
    chk("fetch done busy",   {31'd0, busy}, 32'd0);
    chk("fetch done rvalid", {31'd0, if_rvalid}, 32'd0);

    // contention: DM load wins, IF follows in the next IDLE
    if_req  = 1'b1;
    if_addr = 32'h0100_0004;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0100_0100;
    dm_size = 2'd2;
    #1;
    chk("cont dm_gnt", {31'd0, dm_gnt}, 32'd1);
    chk("cont if_gnt", {31'd0, if_gnt}, 32'd0);
    tick();
    dm_req = 1'b0;
    #1;
    chk("cont issue if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("cont mem_addr", mem_addr, 32'h0100_0100);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    chk("cont dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
    chk("cont dm_rdata",  dm_rdata, 32'hCAFE_F00D);
    chk("cont if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("cont resp if_gnt", {31'd0, if_gnt}, 32'd0);
    tick();
    chk("cont late if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("cont if_rdata hold", if_rdata, 32'h0000_0013);
    tick();
    if_req = 1'b0;
    #1;
    chk("cont fetch addr", mem_addr, 32'h0100_0004);
    chk("cont fetch size", {30'd0, mem_size}, 32'd2);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0010_0093;
    tick();
    mem_ack = 1'b0;
    chk("cont fetch rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd2);
    chk("cont fetch rdata",  if_rdata, 32'h0010_0093);
    tick();

    // store with 3-cycle memory latency
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h0100_0200;
    dm_wdata = 32'hDEAD_BEEF;
    dm_size  = 2'd2;
    #1;
    chk("st dm_gnt", {31'd0, dm_gnt}, 32'd1);
    tick();
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("st mem_req c%0d", i),   {31'd0, mem_req}, 32'd1);
      chk($sformatf("st mem_wdata c%0d", i), mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("st mem_we c%0d", i),    {31'd0, mem_we}, 32'd1);
      chk($sformatf("st no rvalid c%0d", i), {31'd0, dm_rvalid}, 32'd0);
      if (i == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
      end
      tick();
    end
    mem_ack = 1'b0;
    chk("st dm_rvalid",     {31'd0, dm_rvalid}, 32'd1);
    chk("st dm_rdata hold", dm_rdata, 32'hCAFE_F00D);
    chk("st mem_req low",   {31'd0, mem_req}, 32'd0);
    tick();
    chk("st rvalid once", {31'd0, dm_rvalid}, 32'd0);

    // reset in the middle of ISSUE, then a stale ack
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0100_0300;
    tick();
    dm_req = 1'b0;
    #1;
    chk("rstmid mem_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rstmid mem_req low", {31'd0, mem_req}, 32'd0);
    chk("rstmid busy",        {31'd0, busy}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    chk("rstmid rvalids", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    chk("rstmid busy2",   {31'd0, busy}, 32'd0);
    chk("rstmid dm_rdata", dm_rdata, 32'd0);
    tick();
    chk("rstmid rvalids2", {30'd0, if_rvalid, dm_rvalid}, 32'd0);

    // spurious ack while idle
    mem_ack   = 1'b1;
    mem_rdata = 32'hAAAA_AAAA;
    #1;
    chk("spur busy", {31'd0, busy}, 32'd0);
    tick();
    mem_ack = 1'b0;
    chk("spur busy2",   {31'd0, busy}, 32'd0);
    chk("spur rvalids", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    chk("spur if_rdata", if_rdata, 32'd0);
    tick();
    chk("spur rvalids2", {30'd0, if_rvalid, dm_rvalid}, 32'd0);

    // starvation: both requesters held continuously
    if_req  = 1'b1;
    if_addr = 32'h0100_0400;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0100_0500;
    #1;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      serve_one($sformatf("starve g%0d", k), (k % 5) != 4);
`else
      serve_one($sformatf("starve g%0d", k), 1'b1);
`endif
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
